regfile_arbiter_ctrl: RTL and testbench

Synchronous two-requester controller that shares one asynchronous register-file port between two clients. It arbitrates round-robin, sequences the chip-select, output-enable and write-strobe timing, and drives or releases the shared bidirectional data bus. It captures read data and returns a one-cycle acknowledge to the granted requester. It sits between the datapath clients and the register-file storage block.

---
 rtl/regfile_arbiter_ctrl.sv | 176 +++++++++++++++++
 tb/tb_regfile_arbiter_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter_ctrl.sv
// regfile_arbiter_ctrl
// Shares one asynchronous register-file port between two requesters.
// Requests are arbitrated round-robin. The block sequences the chip-select,
// output-enable and write-strobe timing. It drives the shared data bus only
// during write states. Read data is captured when leaving R_CAP, and the
// granted requester receives a one-cycle ack in DONE.
//
// Ports
//   clk              clock, all state changes on the rising edge
//   rst_n            synchronous active-low reset
//   req0/we0/addr0/wdata0, ack0   requester 0 (req held until ack0)
//   req1/we1/addr1/wdata1, ack1   requester 1
//   rdata            captured read data, held until the next read capture
//   busy             high in every state except IDLE
//   rf_cs_n          register-file chip select, active-low
//   rf_oe            register-file output enable (1 = read)
//   rf_ws            register-file write strobe (file writes on its rising edge)
//   rf_addr          register-file address, latched at grant
//   rf_data          shared bidirectional data bus
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | bus idle, arbitrate between pending requests
// S_W_SETUP  | cs asserted, write data driven, strobe low
// S_W_STROBE | strobe high, the file captures data on its rising edge
// S_W_HOLD   | strobe low, data still driven for hold time
// S_R_EN     | cs and oe asserted, bus released to the file
// S_R_CAP    | same as R_EN, rdata is captured on the edge leaving it
// S_DONE     | bus idle, one-cycle ack to the granted requester

module regfile_arbiter_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  rf_cs_n,
    output logic                  rf_oe,
    output logic                  rf_ws,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    inout  wire  [DATA_WIDTH-1:0] rf_data
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_SETUP  = 3'd1,
        S_W_STROBE = 3'd2,
        S_W_HOLD   = 3'd3,
        S_R_EN     = 3'd4,
        S_R_CAP    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t state, next_state;

    // Last granted requester. It doubles as the owner of the transaction in
    // flight, because it is updated at the grant edge and stays stable until
    // the next grant.
    logic                  last_gnt_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  drive_q;

    logic grant_req;
    logic grant_sel;
    logic grant_we;

    logic cs_n_d, oe_d, ws_d, drive_d, ack0_d, ack1_d, busy_d;

    // On contention the winner is the requester that was not granted last.
    assign grant_req = req0 | req1;
    assign grant_sel = (req0 && req1) ? ~last_gnt_q : req1;
    assign grant_we  = grant_sel ? we1 : we0;

    // State register and datapath latches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_gnt_q <= 1'b1;
            wdata_q    <= '0;
            rf_addr    <= '0;
            rdata      <= '0;
            rf_cs_n    <= 1'b1;
            rf_oe      <= 1'b0;
            rf_ws      <= 1'b0;
            drive_q    <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state   <= next_state;
            rf_cs_n <= cs_n_d;
            rf_oe   <= oe_d;
            rf_ws   <= ws_d;
            drive_q <= drive_d;
            ack0    <= ack0_d;
            ack1    <= ack1_d;
            busy    <= busy_d;
            if (state == S_IDLE && grant_req) begin
                last_gnt_q <= grant_sel;
                rf_addr    <= grant_sel ? addr1 : addr0;
                wdata_q    <= grant_sel ? wdata1 : wdata0;
            end
            if (state == S_R_CAP) begin
                rdata <= rf_data;
            end
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (grant_req) next_state = grant_we ? S_W_SETUP : S_R_EN;
            S_W_SETUP:  next_state = S_W_STROBE;
            S_W_STROBE: next_state = S_W_HOLD;
            S_W_HOLD:   next_state = S_DONE;
            S_R_EN:     next_state = S_R_CAP;
            S_R_CAP:    next_state = S_DONE;
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Output decode. Decoding from next_state and registering the result
    // keeps every port glitch-free while each output still matches the
    // state the controller occupies in that cycle.
    always_comb begin
        cs_n_d  = 1'b1;
        oe_d    = 1'b0;
        ws_d    = 1'b0;
        drive_d = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = (next_state != S_IDLE);
        case (next_state)
            S_W_SETUP: begin
                cs_n_d  = 1'b0;
                drive_d = 1'b1;
            end
            S_W_STROBE: begin
                cs_n_d  = 1'b0;
                ws_d    = 1'b1;
                drive_d = 1'b1;
            end
            S_W_HOLD: begin
                cs_n_d  = 1'b0;
                drive_d = 1'b1;
            end
            S_R_EN, S_R_CAP: begin
                cs_n_d = 1'b0;
                oe_d   = 1'b1;
            end
            S_DONE: begin
                ack0_d = ~last_gnt_q;
                ack1_d = last_gnt_q;
            end
            default: ;
        endcase
    end

    // drive_q is only ever set in write states, where oe is low.
    assign rf_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_regfile_arbiter_ctrl.sv
module tb_regfile_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, we0, req1, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    wire        ack0, ack1, busy, rf_cs_n, rf_oe, rf_ws;
    wire  [7:0] rdata;
    wire  [4:0] rf_addr;
    wire  [7:0] rf_data;

    int errors = 0;
    int checks = 0;

    regfile_arbiter_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy), .rf_cs_n(rf_cs_n), .rf_oe(rf_oe),
        .rf_ws(rf_ws), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    // Register-file storage the controller talks to.
    logic [7:0] mem [32];
    int ws_rises = 0;
    assign rf_data = (!rf_cs_n && rf_oe) ? mem[rf_addr] : 8'hzz;
    always @(posedge rf_ws) begin
        mem[rf_addr] = rf_data;
        ws_rises++;
    end

    // Reference model: storage contents as seen by completed transactions,
    // and the round-robin pointer.
    logic [7:0] gold [32];
    int model_last = 1;

    // Protocol monitor
    int  mon_bad = 0;
    int  gap = 0;
    int  min_gap = 99;
    bit  rd_seen = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_seen = 0;
        end else begin
            if (rf_ws && (rf_cs_n || rf_oe)) mon_bad++;
            if (!rf_cs_n && rf_oe && rf_data !== mem[rf_addr]) mon_bad++;
            if (ack0 && ack1) mon_bad++;
            if (!rf_cs_n && rf_oe) begin
                rd_seen = 1;
                gap = 0;
            end else if (rf_cs_n && !rf_oe) begin
                gap++;
            end else if (!rf_cs_n && !rf_oe) begin
                if (rd_seen && gap < min_gap) min_gap = gap;
                rd_seen = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the controller idle.
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
    endtask

    task automatic xact(input int r, input bit we, input logic [4:0] a, input logic [7:0] d);
        int n;
        bit got;
        int wrong;
        int ws0;
        wait_idle();
        ws0 = ws_rises;
        if (r == 0) begin
            req0 = 1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1; we1 = we; addr1 = a; wdata1 = d;
        end
        got = 0; n = 0; wrong = 0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if ((r == 0) ? ack0 : ack1) got = 1;
            if ((r == 0) ? ack1 : ack0) wrong++;
        end
        chk("ack_seen", got, 1);
        chk("latency", n, we ? 4 : 3);
        chk("other_ack", wrong, 0);
        if (r == 0) req0 = 0; else req1 = 0;
        if (we) gold[a] = d;
        else chk("rdata", rdata, gold[a]);
        chk("ws_edges", ws_rises - ws0, we ? 1 : 0);
        model_last = r;
        @(negedge clk);
        chk("ack_pulse", {30'd0, ack1, ack0}, 0);
    endtask

    task automatic pair(input bit w0, input logic [4:0] a0, input logic [7:0] d0,
                        input bit w1, input logic [4:0] a1, input logic [7:0] d1);
        int first, n, k, ws0, first_lat;
        int order [2];
        logic [7:0] exp0, exp1;
        bit done0, done1;
        wait_idle();
        first = (model_last == 0) ? 1 : 0;
        exp0 = 0; exp1 = 0;
        for (int i = 0; i < 2; i++) begin
            int who = (i == 0) ? first : 1 - first;
            if (who == 0) begin
                if (w0) gold[a0] = d0; else exp0 = gold[a0];
            end else begin
                if (w1) gold[a1] = d1; else exp1 = gold[a1];
            end
        end
        ws0 = ws_rises;
        req0 = 1; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = 1; we1 = w1; addr1 = a1; wdata1 = d1;
        done0 = 0; done1 = 0; n = 0; k = 0; first_lat = 0;
        order[0] = -1; order[1] = -1;
        while (!(done0 && done1) && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ack0 && !done0) begin
                done0 = 1; req0 = 0;
                if (k < 2) order[k] = 0;
                if (k == 0) first_lat = n;
                k++;
                if (!w0) chk("pair_rdata0", rdata, exp0);
            end
            if (ack1 && !done1) begin
                done1 = 1; req1 = 0;
                if (k < 2) order[k] = 1;
                if (k == 0) first_lat = n;
                k++;
                if (!w1) chk("pair_rdata1", rdata, exp1);
            end
        end
        req0 = 0; req1 = 0;
        chk("pair_done", {30'd0, done1, done0}, 3);
        chk("pair_order0", order[0], first);
        chk("pair_order1", order[1], 1 - first);
        chk("pair_first_lat", first_lat, ((first == 0) ? w0 : w1) ? 4 : 3);
        chk("pair_ws_edges", ws_rises - ws0, int'(w0) + int'(w1));
        model_last = 1 - first;
        @(negedge clk);
    endtask

    initial begin
        int ws0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'h00;
            gold[i] = 8'h00;
        end
        rst_n = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", rf_cs_n, 1);
        chk("rst_oe", rf_oe, 0);
        chk("rst_ws", rf_ws, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_acks", {30'd0, ack1, ack0}, 0);
        chk("rst_addr", rf_addr, 0);
        rst_n = 1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_cs_n", rf_cs_n, 1);

        // Single write then read, requester 0
        xact(0, 1, 5'd5, 8'hA5);
        xact(0, 0, 5'd5, 8'h00);

        // Contention round-robin from a fresh reset
        reset_dut();
        pair(1, 5'd3, 8'h11, 1, 5'd7, 8'h22);
        pair(0, 5'd3, 8'h00, 0, 5'd7, 8'h00);

        // Read followed immediately by a write
        min_gap = 99;
        xact(0, 0, 5'd3, 8'h00);
        xact(0, 1, 5'd4, 8'h5A);
        chk("turnaround", min_gap >= 2, 1);

        // Boundary addresses
        xact(0, 1, 5'd0, 8'hFF);
        xact(1, 1, 5'd31, 8'h80);
        xact(0, 0, 5'd0, 8'h00);
        xact(1, 0, 5'd31, 8'h00);

        // Reset during W_SETUP: no write, no ack
        wait_idle();
        ws0 = ws_rises;
        req0 = 1; we0 = 1; addr0 = 5'd9; wdata0 = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        chk("wsetup_busy", busy, 1);
        chk("wsetup_ws", rf_ws, 0);
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        req0 = 0;
        chk("abort_w_ack", ack0, 0);
        chk("abort_w_cs_n", rf_cs_n, 1);
        chk("abort_w_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_last = 1;
        chk("abort_w_ws_edges", ws_rises - ws0, 0);
        xact(0, 0, 5'd9, 8'h00);

        // Reset during a read clears rdata and suppresses the ack
        xact(1, 0, 5'd31, 8'h00);
        wait_idle();
        req0 = 1; we0 = 0; addr0 = 5'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rcap_oe", rf_oe, 1);
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        req0 = 0;
        chk("abort_r_rdata", rdata, 0);
        chk("abort_r_ack", ack0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_last = 1;

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            int mode = $urandom_range(0, 2);
            bit wa = $urandom_range(0, 1);
            bit wb = $urandom_range(0, 1);
            logic [4:0] aa = 5'($urandom_range(0, 31));
            logic [4:0] ab = 5'($urandom_range(0, 31));
            logic [7:0] da = 8'($urandom_range(0, 255));
            logic [7:0] db = 8'($urandom_range(0, 255));
            if (mode == 2) pair(wa, aa, da, wb, ab, db);
            else xact(mode, wa, aa, da);
        end

        chk("monitor", mon_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
